csa_accum_ctrl: RTL and testbench

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

---
 rtl/pdpu_pkg.sv | 32 +++
 rtl/compressor_3to2.sv | 27 ++
 rtl/csa_accum_ctrl.sv | 106 ++++++++++
 tb/tb_csa_accum_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdpu_pkg.sv
// ----------------------------------------------------------------------------
// pdpu_pkg: shared FSM state type and width helper for the accumulator block.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pdpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Smallest r with 2**r >= value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/compressor_3to2.sv
// ----------------------------------------------------------------------------
// compressor_3to2: bitwise full-adder row reducing three operands to sum/carry.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module compressor_3to2 #(
  parameter int WIDTH_I = 8
) (
  input  logic [WIDTH_I-1:0] a_i,
  input  logic [WIDTH_I-1:0] b_i,
  input  logic [WIDTH_I-1:0] c_i,
  output logic [WIDTH_I-1:0] sum_o,
  output logic [WIDTH_I:0]   carry_o
);

  logic [WIDTH_I-1:0] majority;

  assign sum_o    = a_i ^ b_i ^ c_i;
  assign majority = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  // Carry bits carry weight 2, so the vector is pre-shifted one place.
  assign carry_o  = {majority, 1'b0};

endmodule

`default_nettype wire

// File: rtl/csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// csa_accum_ctrl: carry-save accumulator with job FSM and one final resolve add.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module csa_accum_ctrl
  import pdpu_pkg::*;
#(
  parameter int WIDTH_I = 8,
  parameter int N_MAX   = 16,
  parameter int WIDTH_A = WIDTH_I + pdpu_pkg::clog2(N_MAX)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [pdpu_pkg::clog2(N_MAX+1)-1:0]    count_i,
  input  logic                                   operand_valid_i,
  input  logic [WIDTH_I-1:0]                     operand_i,
  output logic                                   operand_ready_o,
  output logic                                   result_valid_o,
  input  logic                                   result_ready_i,
  output logic [WIDTH_A-1:0]                     result_o,
  output logic                                   busy_o
);

  localparam int CNT_W = pdpu_pkg::clog2(N_MAX + 1);

  state_t             state_q;
  logic [WIDTH_A-1:0] sum_q;
  logic [WIDTH_A-1:0] carry_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH_A-1:0] result_q;

  logic [CNT_W-1:0]   count_load;
  logic [WIDTH_A-1:0] operand_ext;
  logic [WIDTH_A-1:0] csa_sum;
  logic [WIDTH_A:0]   csa_carry;
  logic [WIDTH_A-1:0] carry_trunc;

  assign count_load  = (count_i > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : count_i;
  assign operand_ext = WIDTH_A'(operand_i);

  compressor_3to2 #(
    .WIDTH_I (WIDTH_A)
  ) u_csa (
    .a_i     (operand_ext),
    .b_i     (sum_q),
    .c_i     (carry_q),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  // Dropping the carry MSB gives the mod 2^WIDTH_A wrap of the running sum.
  assign carry_trunc = WIDTH_A'(csa_carry);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      carry_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            sum_q   <= '0;
            carry_q <= '0;
            count_q <= count_load;
            state_q <= (count_load == '0) ? ST_RESOLVE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (operand_valid_i) begin
            sum_q   <= csa_sum;
            carry_q <= carry_trunc;
            count_q <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_q <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          result_q <= sum_q + carry_q;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (result_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign operand_ready_o = (state_q == ST_ACCUM);
  assign result_valid_o  = (state_q == ST_DONE);
  assign busy_o          = (state_q != ST_IDLE);
  assign result_o        = result_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csa_accum_ctrl: directed and random jobs against a modular-sum model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_csa_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [4:0]  count;
  logic        op_valid;
  logic [7:0]  operand;
  logic        res_ready;

  logic        ready_a, valid_a, busy_a;
  logic [11:0] result_a;
  logic        ready_b, valid_b, busy_b;
  logic [9:0]  result_b;

  logic        sel;
  logic        ready_m, valid_m, busy_m;
  logic [11:0] result_m;

  int checks = 0;
  int errors = 0;
  int ops [0:31];

  always #5 clk = ~clk;

  csa_accum_ctrl dut_a (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start_a),
    .count_i         (count),
    .operand_valid_i (op_valid),
    .operand_i       (operand),
    .operand_ready_o (ready_a),
    .result_valid_o  (valid_a),
    .result_ready_i  (res_ready),
    .result_o        (result_a),
    .busy_o          (busy_a)
  );

  // Narrow accumulator with larger N_MAX so full-scale jobs wrap.
  csa_accum_ctrl #(
    .WIDTH_I (8),
    .N_MAX   (20),
    .WIDTH_A (10)
  ) dut_b (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start_b),
    .count_i         (count),
    .operand_valid_i (op_valid),
    .operand_i       (operand),
    .operand_ready_o (ready_b),
    .result_valid_o  (valid_b),
    .result_ready_i  (res_ready),
    .result_o        (result_b),
    .busy_o          (busy_b)
  );

  assign ready_m  = sel ? ready_b : ready_a;
  assign valid_m  = sel ? valid_b : valid_a;
  assign busy_m   = sel ? busy_b  : busy_a;
  assign result_m = sel ? {2'b00, result_b} : result_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which != 0) start_b = v;
    else            start_a = v;
  endtask

  // One complete job on the selected instance; operands come from ops[].
  task automatic run_job(input int which, input int cnt, input bit gaps, input int hold);
    int          nmax;
    int          wa;
    int          eff;
    longint      total;
    logic [31:0] exp;
    nmax  = (which != 0) ? 20 : 16;
    wa    = (which != 0) ? 10 : 12;
    eff   = (cnt > nmax) ? nmax : cnt;
    total = 0;
    for (int i = 0; i < eff; i++) total += ops[i];
    exp = 32'(total & ((64'd1 << wa) - 1));
    sel = (which != 0);

    @(negedge clk);
    count = 5'(cnt);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    count = 5'($urandom);
    check("busy_after_start", busy_m, 1);
    check("ready_after_start", ready_m, (eff > 0) ? 1 : 0);

    for (int i = 0; i < eff; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          op_valid = 1'b0;
          operand  = 8'($urandom);
          @(negedge clk);
          check("ready_in_gap", ready_m, 1);
        end
      end
      op_valid = 1'b1;
      operand  = 8'(ops[i]);
      check("ready_accum", ready_m, 1);
      @(negedge clk);
    end
    op_valid = 1'b0;
    operand  = 8'($urandom);
    check("valid_in_resolve", valid_m, 0);
    check("ready_after_last", ready_m, 0);

    @(negedge clk);
    check("valid_done", valid_m, 1);
    check("result", result_m, exp);

    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      set_start(which, h[0]);
      @(negedge clk);
      check("hold_valid", valid_m, 1);
      check("hold_result", result_m, exp);
    end

    // A start coinciding with the DONE->IDLE edge must not launch a job.
    res_ready = 1'b1;
    set_start(which, 1'b1);
    @(negedge clk);
    res_ready = 1'b0;
    set_start(which, 1'b0);
    check("idle_busy", busy_m, 0);
    check("idle_valid", valid_m, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    count     = '0;
    op_valid  = 1'b0;
    operand   = '0;
    res_ready = 1'b0;
    sel       = 1'b0;
    for (int i = 0; i < 32; i++) ops[i] = 0;

    #12;
    check("rst_busy", busy_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_result", result_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ops[0] = 1; ops[1] = 2; ops[2] = 3;
    run_job(0, 3, 1'b0, 0);

    for (int i = 0; i < 16; i++) ops[i] = 8'hFF;
    run_job(0, 16, 1'b0, 0);

    run_job(0, 0, 1'b0, 0);

    ops[0] = 10; ops[1] = 20; ops[2] = 30; ops[3] = 40;
    run_job(0, 4, 1'b1, 0);

    ops[0] = 5; ops[1] = 6; ops[2] = 7;
    run_job(0, 3, 1'b0, 5);

    for (int i = 0; i < 16; i++) ops[i] = i + 1;
    run_job(0, 25, 1'b1, 0);

    // Abandon a job mid-stream; result_a still holds the previous 136.
    sel = 1'b0;
    @(negedge clk);
    count   = 5'd5;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1;
      operand  = 8'(50 + i);
      @(negedge clk);
    end
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_ready", ready_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_result", result_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ops[0] = 7; ops[1] = 9;
    run_job(0, 2, 1'b0, 0);

    for (int i = 0; i < 20; i++) ops[i] = 8'hFF;
    run_job(1, 20, 1'b0, 0);

    for (int j = 0; j < 16; j++) begin
      int which;
      which = j % 2;
      for (int i = 0; i < 32; i++) ops[i] = int'($urandom_range(0, 255));
      run_job(which, int'($urandom_range(0, (which != 0) ? 23 : 19)),
              1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
